rename_regfile: RTL

Parametrised multi-port renamed physical register file with per-architectural-register rename tracking. Each architectural register owns `2**RNBIT` physical slots used as a circular buffer. The block tracks three things per register: the speculative (latest) slot, the committed slot, and the in-flight count. Each slot carries a ready (written) bit. It sits between rename/dispatch (allocate), execute writeback, issue (operand read) and commit/flush.

---
 rtl/rename_regfile.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rename_regfile.sv
// Renamed physical register file: each architectural register owns a circular buffer of
// 2**RNBIT slots with speculative/committed pointers, an in-flight count and per-slot ready bits.
module rename_regfile #(
    parameter int DW       = 64,
    parameter int ARCH     = 32,
    parameter int RNBIT    = 2,
    parameter int RD_PORTS = 4,
    parameter int WR_PORTS = 4,
    parameter int BYPASS   = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         alloc_valid,
    input  logic [4:0]                   alloc_index,
    output logic                         alloc_ready,
    output logic [RNBIT-1:0]             alloc_rename,
    input  logic [WR_PORTS-1:0]          wb_valid,
    input  logic [5*WR_PORTS-1:0]        wb_index,
    input  logic [RNBIT*WR_PORTS-1:0]    wb_rename,
    input  logic [DW*WR_PORTS-1:0]       wb_data,
    input  logic [5*RD_PORTS-1:0]        rd_index,
    input  logic [RNBIT*RD_PORTS-1:0]    rd_rename,
    output logic [DW*RD_PORTS-1:0]       rd_data,
    output logic [RD_PORTS-1:0]          rd_ready,
    input  logic                         commit_valid,
    input  logic [4:0]                   commit_index,
    input  logic                         flush,
    output logic                         commit_err
);

    localparam int IW      = 5;
    localparam int SW      = IW + RNBIT;
    localparam int RNDEPTH = 2 ** RNBIT;
    localparam int NSLOT   = ARCH * RNDEPTH;
    localparam logic [RNBIT-1:0] PTR_ONE = 1;
    localparam logic [RNBIT:0]   CNT_ONE = 1;
    localparam logic [RNBIT:0]   CNT_MAX = (RNBIT + 1)'(RNDEPTH - 1);

    logic [RNBIT-1:0] r_spec_ptr [ARCH];
    logic [RNBIT-1:0] r_arch_ptr [ARCH];
    logic [RNBIT:0]   r_cnt      [ARCH];
    logic [RNBIT-1:0] w_spec_nxt [ARCH];
    logic [RNBIT-1:0] w_arch_nxt [ARCH];
    logic [RNBIT:0]   w_cnt_nxt  [ARCH];
    logic             r_commit_err;

    logic [RNBIT-1:0] w_alloc_slot;
    logic             w_alloc_fire;
    logic             w_commit_fire;
    logic             w_commit_bad;
    logic [RNBIT:0]   w_commit_cnt;

    logic [DW-1:0]    w_slot_data [NSLOT];
    logic [NSLOT-1:0] w_slot_rdy;

    assign commit_err = r_commit_err;

    // Allocation grant and commit qualification from current state
    always_comb begin
        w_alloc_slot = r_spec_ptr[alloc_index] + PTR_ONE;
        w_commit_cnt = r_cnt[commit_index];
        if (flush) begin
            alloc_ready = 1'b0;
        end else if (alloc_index == 5'd0) begin
            alloc_ready = 1'b1;
        end else begin
            alloc_ready = (r_cnt[alloc_index] < CNT_MAX);
        end
        alloc_rename  = (alloc_index == 5'd0) ? '0 : w_alloc_slot;
        w_alloc_fire  = alloc_valid && alloc_ready && (alloc_index != 5'd0);
        w_commit_fire = commit_valid && (commit_index != 5'd0) && (w_commit_cnt != '0);
        w_commit_bad  = commit_valid && (commit_index != 5'd0) && (w_commit_cnt == '0);
    end

    // Next-state of the per-register pointers and in-flight counts
    always_comb begin
        w_spec_nxt = r_spec_ptr;
        w_arch_nxt = r_arch_ptr;
        w_cnt_nxt  = r_cnt;
        for (int r = 1; r < ARCH; r++) begin
            logic hit_a;
            logic hit_c;
            hit_a = w_alloc_fire && (alloc_index == IW'(r));
            hit_c = w_commit_fire && (commit_index == IW'(r));
            w_arch_nxt[r] = hit_c ? (r_arch_ptr[r] + PTR_ONE) : r_arch_ptr[r];
            // Flush rolls speculation back onto the post-commit architectural pointer
            if (flush) begin
                w_spec_nxt[r] = w_arch_nxt[r];
                w_cnt_nxt[r]  = '0;
            end else begin
                w_spec_nxt[r] = hit_a ? (r_spec_ptr[r] + PTR_ONE) : r_spec_ptr[r];
                case ({hit_a, hit_c})
                    2'b10:   w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
                    2'b01:   w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
                    default: w_cnt_nxt[r] = r_cnt[r];
                endcase
            end
        end
    end

    // Rename tracking state and commit error pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_spec_ptr   <= '{default: '0};
            r_arch_ptr   <= '{default: '0};
            r_cnt        <= '{default: '0};
            r_commit_err <= 1'b0;
        end else begin
            r_spec_ptr   <= w_spec_nxt;
            r_arch_ptr   <= w_arch_nxt;
            r_cnt        <= w_cnt_nxt;
            r_commit_err <= w_commit_bad;
        end
    end

    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        localparam logic [SW-1:0] SID = SW'(s);
        logic          w_we;
        logic          w_clr;
        logic [DW-1:0] w_wd;
        logic [DW-1:0] r_data;
        logic          r_rdy;

        // Writeback select for this slot; descending scan lets the lowest port win
        always_comb begin
            w_we  = 1'b0;
            w_wd  = '0;
            w_clr = w_alloc_fire && ({alloc_index, w_alloc_slot} == SID);
            for (int q = WR_PORTS - 1; q >= 0; q--) begin
                logic hit;
                hit  = wb_valid[q] && (wb_index[q*IW +: IW] != 5'd0) &&
                       ({wb_index[q*IW +: IW], wb_rename[q*RNBIT +: RNBIT]} == SID);
                w_we = w_we | hit;
                w_wd = hit ? wb_data[q*DW +: DW] : w_wd;
            end
        end

        // Slot storage; a writeback outranks the ready-clear of a fresh allocation
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_data <= '0;
                r_rdy  <= 1'b1;
            end else if (w_we) begin
                r_data <= w_wd;
                r_rdy  <= 1'b1;
            end else if (w_clr) begin
                r_rdy  <= 1'b0;
            end else begin
                r_rdy  <= r_rdy;
            end
        end

        assign w_slot_data[s] = r_data;
        assign w_slot_rdy[s]  = r_rdy;
    end

    // Operand reads; register 0 slots are never written so they read as 0 / ready
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_data[p*DW +: DW] = w_slot_data[{rd_index[p*IW +: IW], rd_rename[p*RNBIT +: RNBIT]}];
            rd_ready[p]         = w_slot_rdy[{rd_index[p*IW +: IW], rd_rename[p*RNBIT +: RNBIT]}];
            for (int q = WR_PORTS - 1; q >= 0; q--) begin
                logic fwd;
                fwd = (BYPASS != 0) && wb_valid[q] && (wb_index[q*IW +: IW] != 5'd0) &&
                      (wb_index[q*IW +: IW] == rd_index[p*IW +: IW]) &&
                      (wb_rename[q*RNBIT +: RNBIT] == rd_rename[p*RNBIT +: RNBIT]);
                rd_data[p*DW +: DW] = fwd ? wb_data[q*DW +: DW] : rd_data[p*DW +: DW];
                rd_ready[p]         = fwd ? 1'b1 : rd_ready[p];
            end
        end
    end

endmodule
